// File: rtl/jk_pkg.sv
// jk_pkg -- shared definitions for the JK-cell modulo counter.
//   jk_op_t      : JK cell operation encoding, {j,k}
//   params_legal : elaboration-time check of WIDTH/MODULUS legality
package jk_pkg;

    typedef enum logic [1:0] {
        HOLD   = 2'b00,
        RESET  = 2'b01,
        SET    = 2'b10,
        TOGGLE = 2'b11
    } jk_op_t;

    // WIDTH in 1..16, MODULUS in 2..2**WIDTH
    function automatic bit params_legal(input int width, input int modulus);
        return (width >= 1) && (width <= 16) &&
               (modulus >= 2) && (modulus <= (1 << width));
    endfunction

endpackage

// File: rtl/jk_cell.sv
// jk_cell -- single JK flip-flop with synchronous active-low reset to 0.
//   clk   : clock, rising edge
//   rst_n : synchronous reset, active low
//   j, k  : JK drive, decoded with jk_pkg::jk_op_t
//   q     : stored bit
//   qn    : complement of q
module jk_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qn
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            case (jk_op_t'({j, k}))
                HOLD:    q <= q;
                RESET:   q <= 1'b0;
                SET:     q <= 1'b1;
                TOGGLE:  q <= ~q;
            endcase
        end
    end

    assign qn = ~q;

endmodule

// File: rtl/jk_mod_counter.sv
// jk_mod_counter -- up/down modulo-MODULUS counter built from JK cells.
//   clk     : clock, rising edge
//   rst_n   : synchronous reset, active low (q=0, ovf=0)
//   en      : count enable
//   up      : direction, 1 = up, 0 = down
//   load    : synchronous load of din (clamped to MODULUS-1), beats en
//   din     : load value
//   clr_ovf : clears sticky overflow (a wrap on the same edge wins)
//   q       : registered count
//   qn      : complement of q
//   tc      : terminal count, high when the next edge wraps
//   ovf     : sticky wrap flag
module jk_mod_counter
    import jk_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             tc,
    output logic             ovf
);

    if (!params_legal(WIDTH, MODULUS)) begin : g_param_check
        $error("jk_mod_counter: WIDTH/MODULUS out of legal range");
    end

    localparam logic [WIDTH-1:0] MAX_Q      = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT    = (WIDTH+1)'(MODULUS);
    // A full-range modulus wraps naturally in binary arithmetic.
    localparam bit               FULL_RANGE = (MODULUS == (1 << WIDTH));

    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             at_max;
    logic             at_zero;

    assign at_max  = (q == MAX_Q);
    assign at_zero = (q == '0);
    assign tc      = en & ~load & ((up & at_max) | (~up & at_zero));

    // Next-state value of the count
    always_comb begin
        d = q;
        if (load) begin
            if (FULL_RANGE || ({1'b0, din} < MOD_EXT)) d = din;
            else                                       d = MAX_Q;
        end else if (en) begin
            if (FULL_RANGE) d = up ? q + WIDTH'(1) : q - WIDTH'(1);
            else if (up)    d = at_max  ? '0    : q + WIDTH'(1);
            else            d = at_zero ? MAX_Q : q - WIDTH'(1);
        end
    end

    // Only bits that must change get a set or reset; all others hold.
    assign j = d & ~q;
    assign k = ~d & q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .j     (j[i]),
            .k     (k[i]),
            .q     (q[i]),
            .qn    (qn[i])
        );
    end

    // Sticky overflow: set on a wrap edge, set beats clear
    always_ff @(posedge clk) begin
        if (!rst_n)       ovf <= 1'b0;
        else if (tc)      ovf <= 1'b1;
        else if (clr_ovf) ovf <= 1'b0;
    end

endmodule

// File: tb/tb_jk_mod_counter.sv
// tb_jk_mod_counter -- drives a default (4-bit, mod 10) and a 3-bit mod 8
// counter with shared stimulus, checks both against a modulo-arithmetic
// model every cycle plus hand-computed literal sequences.
module tb_jk_mod_counter;

    localparam int MOD_A = 10;
    localparam int MOD_B = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [3:0] din_a = '0;
    logic [2:0] din_b = '0;

    logic [3:0] q_a, qn_a;
    logic [2:0] q_b, qn_b;
    logic       tc_a, tc_b, ovf_a, ovf_b;

    int checks = 0;
    int failures = 0;
    bit check_en = 1'b0;

    logic [15:0] exp_q[$];

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    jk_mod_counter #(.WIDTH(4), .MODULUS(MOD_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .din(din_a), .clr_ovf(clr_ovf), .q(q_a), .qn(qn_a), .tc(tc_a), .ovf(ovf_a)
    );

    jk_mod_counter #(.WIDTH(3), .MODULUS(MOD_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .din(din_b), .clr_ovf(clr_ovf), .q(q_b), .qn(qn_b), .tc(tc_b), .ovf(ovf_b)
    );

    // ---------------- model ----------------
    int m_q[2];
    int m_ovf[2];
    int m_mod[2] = '{MOD_A, MOD_B};

    function automatic int model_tc(input int i);
        return (en && !load &&
                ((up && m_q[i] == m_mod[i] - 1) || (!up && m_q[i] == 0))) ? 1 : 0;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int dv;
            int wrap;
            dv = (i == 0) ? int'(din_a) : int'(din_b);
            if (!rst_n) begin
                m_q[i]   = 0;
                m_ovf[i] = 0;
            end else begin
                wrap = model_tc(i);
                if (load)
                    m_q[i] = (dv < m_mod[i]) ? dv : m_mod[i] - 1;
                else if (en)
                    m_q[i] = up ? (m_q[i] + 1) % m_mod[i]
                                : (m_q[i] + m_mod[i] - 1) % m_mod[i];
                if (wrap != 0)   m_ovf[i] = 1;
                else if (clr_ovf) m_ovf[i] = 0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("model_q_a",   int'(q_a),   m_q[0]);
            chk("model_qn_a",  int'(qn_a),  15 - m_q[0]);
            chk("model_tc_a",  int'(tc_a),  model_tc(0));
            chk("model_ovf_a", int'(ovf_a), m_ovf[0]);
            chk("range_q_a",   int'(q_a) < MOD_A ? 1 : 0, 1);
            chk("model_q_b",   int'(q_b),   m_q[1]);
            chk("model_qn_b",  int'(qn_b),  7 - m_q[1]);
            chk("model_tc_b",  int'(tc_b),  model_tc(1));
            chk("model_ovf_b", int'(ovf_b), m_ovf[1]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input logic e, input logic u, input logic l,
                        input logic [3:0] d, input logic c);
        en = e; up = u; load = l; din_a = d; din_b = d[2:0]; clr_ovf = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1'b1, 1'b1, 1'b1, 4'd3, 1'b1);
        step(1'b1, 1'b0, 1'b1, 4'd3, 1'b0);
        rst_n = 1'b1;
        en = 1'b0; load = 1'b0; clr_ovf = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int exp_b[12];
        exp_b = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3, 4};

        do_reset();
        check_en = 1'b1;
        chk("reset_q_a",   int'(q_a),   0);
        chk("reset_ovf_a", int'(ovf_a), 0);
        chk("reset_qn_a",  int'(qn_a),  15);
        chk("reset_qn_b",  int'(qn_b),  7);

        // Up count 12 edges
        for (int v = 1; v <= 9; v++) exp_q.push_back(16'(v));
        exp_q.push_back(16'd0); exp_q.push_back(16'd1); exp_q.push_back(16'd2);
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
            chk("up_seq_q_a",   int'(q_a),   int'(exp_q.pop_front()));
            chk("up_seq_ovf_a", int'(ovf_a), (i >= 9) ? 1 : 0);
            chk("up_seq_tc_a",  int'(tc_a),  (i == 8) ? 1 : 0);
            chk("up_seq_q_b",   int'(q_b),   exp_b[i]);
            chk("up_seq_ovf_b", int'(ovf_b), (i >= 7) ? 1 : 0);
        end

        // Down count from 0
        do_reset();
        en = 1'b1; up = 1'b0; load = 1'b0;
        #1;
        chk("down_first_tc_a", int'(tc_a), 1);
        exp_q.push_back(16'd9); exp_q.push_back(16'd8); exp_q.push_back(16'd7);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
            chk("down_seq_q_a", int'(q_a), int'(exp_q.pop_front()));
            chk("down_ovf_a",   int'(ovf_a), 1);
            chk("down_seq_q_b", int'(q_b), 7 - i);
        end

        // Load and clamp
        step(1'b1, 1'b0, 1'b1, 4'd7, 1'b0);
        chk("load7_q_a",   int'(q_a),   7);
        chk("load7_ovf_a", int'(ovf_a), 1);
        chk("load7_q_b",   int'(q_b),   7);
        step(1'b1, 1'b1, 1'b1, 4'd13, 1'b0);
        chk("load13_clamp_q_a", int'(q_a), 9);
        chk("load13_q_b",       int'(q_b), 5);

        // Wrap and clear on the same edge: set wins
        step(1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
        chk("wrap_clr_q_a",   int'(q_a),   0);
        chk("wrap_clr_ovf_a", int'(ovf_a), 1);
        chk("clr_nowrap_ovf_b", int'(ovf_b), 0);
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        chk("clr_ovf_a", int'(ovf_a), 0);

        // Reset mid-count beats load
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("count_to6_q_a", int'(q_a), 6);
        rst_n = 1'b0;
        step(1'b1, 1'b1, 1'b1, 4'd3, 1'b0);
        chk("rst_mid_q_a",   int'(q_a),   0);
        chk("rst_mid_ovf_a", int'(ovf_a), 0);
        chk("rst_mid_qn_a",  int'(qn_a),  15);
        chk("rst_mid_q_b",   int'(q_b),   0);
        rst_n = 1'b1;
        step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("resume_q_a", int'(q_a), 1);

        // Same-edge direction change, then hold
        step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("dir_down_q_a", int'(q_a), 0);
        step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("dir_wrap_q_a", int'(q_a), 9);
        step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("dir_up_q_a", int'(q_a), 0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 4'd5, 1'b0);
        chk("hold_q_a",   int'(q_a),   0);
        chk("hold_ovf_a", int'(ovf_a), 1);

        // Mixed stimulus, checked by the model only
        for (int i = 0; i < 80; i++) begin
            rst_n = ($urandom_range(0, 24) != 0);
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 5) == 0));
        end
        rst_n = 1'b1;
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);

        // ---------------- report ----------------
        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
